// File: rtl/mult_div_unit_pkg.sv
// Shared CPU constants for the multiply/divide unit: op encoding, FSM states
// and the MFHI/MFLO funct codes used by the control unit's MemToReg select.
package mult_div_unit_pkg;

  localparam int unsigned MD_DATA_W_DEF = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;

endpackage

// File: rtl/mult_div_unit_md_step.sv
// One iteration of the shared 2W+1-bit accumulator: Booth radix-2 add/sub plus
// arithmetic shift for MULT, or restoring shift/compare/subtract for DIV.
module mult_div_unit_md_step
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W_DEF
) (
  input  logic                op,
  input  logic [2*DATA_W:0]   acc_i,
  input  logic [DATA_W-1:0]   m_i,
  output logic [2*DATA_W:0]   acc_o
);

  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W:0]   booth_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_rem;
  logic              div_ge;

  // Booth: upper half is summed at W+1 bits so the true sign survives the shift
  always_comb begin
    acc_hi = acc_i[2*DATA_W:DATA_W+1];
    case (acc_i[1:0])
      2'b01:   booth_sum = {acc_hi[DATA_W-1], acc_hi} + {m_i[DATA_W-1], m_i};
      2'b10:   booth_sum = {acc_hi[DATA_W-1], acc_hi} - {m_i[DATA_W-1], m_i};
      default: booth_sum = {acc_hi[DATA_W-1], acc_hi};
    endcase
  end

  // Restoring: remainder in acc[2W:W], quotient bits shift in at acc[0]
  always_comb begin
    div_shift = {acc_i[2*DATA_W-1:DATA_W], acc_i[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, m_i});
    div_rem   = div_ge ? (div_shift - {1'b0, m_i}) : div_shift;
  end

  always_comb begin
    if (op == MD_MULT) acc_o = {booth_sum, acc_i[DATA_W:1]};
    else               acc_o = {div_rem, acc_i[DATA_W-2:0], div_ge};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed MULT/DIV unit with HI/LO result registers; one
// accumulator iteration per clock over DATA_W cycles.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned ACC_W = 2 * DATA_W + 1;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic              op_q, op_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_zero_q, div_zero_d;

  logic [ACC_W-1:0]  acc_step;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] quo, rem;
  logic [DATA_W-1:0] res_hi, res_lo;

  mult_div_unit_md_step #(.DATA_W(DATA_W)) u_step (
    .op    (op_q),
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (acc_step)
  );

  always_comb begin
    a_mag = a[DATA_W-1] ? (~a + DATA_W'(1)) : a;
    b_mag = b[DATA_W-1] ? (~b + DATA_W'(1)) : b;
  end

  // Final-iteration result with sign fix-up for DIV
  always_comb begin
    quo = acc_step[DATA_W-1:0];
    rem = acc_step[2*DATA_W-1:DATA_W];
    if (op_q == MD_MULT) begin
      res_hi = acc_step[2*DATA_W:DATA_W+1];
      res_lo = acc_step[DATA_W:1];
    end else begin
      res_hi = r_neg_q ? (~rem + DATA_W'(1)) : rem;
      res_lo = q_neg_q ? (~quo + DATA_W'(1)) : quo;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    m_d        = m_q;
    op_d       = op_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      MD_RUN: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          state_d = MD_DONE;
          done_d  = 1'b1;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        if (start) begin
          if (op == MD_DIV && b == '0) begin
            // Divide by zero: flag it, skip RUN, keep HI/LO
            state_d    = MD_DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d = MD_RUN;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(DATA_W - 1);
            op_d    = op;
            q_neg_d = a[DATA_W-1] ^ b[DATA_W-1];
            r_neg_d = a[DATA_W-1];
            if (op == MD_MULT) begin
              acc_d = {DATA_W'(0), b, 1'b0};
              m_d   = a;
            end else begin
              acc_d = {(DATA_W + 1)'(0), a_mag};
              m_d   = b_mag;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      op_q       <= MD_MULT;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      m_q        <= m_d;
      op_q       <= op_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
